eb1_ghr_chkpt: RTL and testbench

EB1_GHR_CHKPT -- requirements
Module: eb1_ghr_chkpt

---
 rtl/eb1_ghr_chkpt.sv | 96 +++++++++
 tb/tb_eb1_ghr_chkpt.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eb1_ghr_chkpt.sv
// Speculative global-history register with a circular checkpoint buffer so the
// frontend can restore history on a branch mispredict and retire branches in order.
module eb1_ghr_chkpt #(
  parameter int BHT_GHR_SIZE = 8,
  parameter int CHKPT_DEPTH  = 4,
  parameter int CHKPT_TAGW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    pred_valid,
  input  logic                    pred_taken,
  output logic                    pred_ready,
  output logic [CHKPT_TAGW-1:0]   pred_tag,
  output logic [BHT_GHR_SIZE-1:0] ghr,
  input  logic                    retire_valid,
  input  logic                    flush_valid,
  input  logic [CHKPT_TAGW-1:0]   flush_tag,
  input  logic                    flush_taken,
  output logic [CHKPT_TAGW:0]     chkpt_count,
  output logic                    chkpt_err
);

  localparam int PW = CHKPT_TAGW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(CHKPT_DEPTH);

  logic [PW-1:0]           wrPtr_q, wrPtr_d;
  logic [PW-1:0]           rdPtr_q, rdPtr_d;
  logic [BHT_GHR_SIZE-1:0] ghr_q, ghr_d;
  logic                    err_q, err_d;
  logic [BHT_GHR_SIZE-1:0] slotMem [CHKPT_DEPTH];

  logic [PW-1:0]         count;
  logic [CHKPT_TAGW-1:0] flushOff;
  logic                  retireOk;
  logic                  flushApply;
  logic                  predApply;

  assign count       = wrPtr_q - rdPtr_q;
  assign pred_ready  = (count < DEPTH_P);
  assign pred_tag    = wrPtr_q[CHKPT_TAGW-1:0];
  assign ghr         = ghr_q;
  assign chkpt_count = count;
  assign chkpt_err   = err_q;

  // Flush legality uses the pre-retire state; flushing the head being retired is illegal.
  assign flushOff   = flush_tag - rdPtr_q[CHKPT_TAGW-1:0];
  assign retireOk   = retire_valid && (count != '0);
  assign flushApply = flush_valid && ({1'b0, flushOff} < count)
                      && !(retireOk && (flushOff == '0));
  assign predApply  = pred_valid && pred_ready && !flush_valid;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    ghr_d   = ghr_q;
    err_d   = err_q;

    if (flushApply) begin
      wrPtr_d = rdPtr_q + PW'(flushOff) + PW'(1);
      ghr_d   = {slotMem[flush_tag][BHT_GHR_SIZE-2:0], flush_taken};
    end else if (predApply) begin
      wrPtr_d = wrPtr_q + PW'(1);
      ghr_d   = {ghr_q[BHT_GHR_SIZE-2:0], pred_taken};
    end

    if (retireOk) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    if ((flush_valid && !flushApply) || (retire_valid && (count == '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      ghr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      ghr_q   <= ghr_d;
      err_q   <= err_d;
    end
  end

  // Slot storage is never read before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (predApply) begin
      slotMem[wrPtr_q[CHKPT_TAGW-1:0]] <= ghr_q;
    end
  end

endmodule

// File: tb/tb_eb1_ghr_chkpt.sv
// Scoreboard bench for eb1_ghr_chkpt: a queue-of-snapshots reference model predicts
// each post-edge state and a negedge monitor compares it with the DUT.
module tb_eb1_ghr_chkpt;

  localparam int G  = 8;
  localparam int D  = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst_l = 1'b1;
  logic          pred_valid = 1'b0;
  logic          pred_taken = 1'b0;
  logic          pred_ready;
  logic [TW-1:0] pred_tag;
  logic [G-1:0]  ghr;
  logic          retire_valid = 1'b0;
  logic          flush_valid = 1'b0;
  logic [TW-1:0] flush_tag = '0;
  logic          flush_taken = 1'b0;
  logic [TW:0]   chkpt_count;
  logic          chkpt_err;

  eb1_ghr_chkpt #(.BHT_GHR_SIZE(G), .CHKPT_DEPTH(D), .CHKPT_TAGW(TW)) dut (
    .clk(clk), .rst_l(rst_l),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .pred_tag(pred_tag), .ghr(ghr),
    .retire_valid(retire_valid), .flush_valid(flush_valid),
    .flush_tag(flush_tag), .flush_taken(flush_taken),
    .chkpt_count(chkpt_count), .chkpt_err(chkpt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ghrV;
    int countV;
    int readyV;
    int tagV;
    int errV;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFail   = 0;

  // Reference model: in-flight branches as a queue of history snapshots, oldest first.
  logic [G-1:0] mGhr;
  logic [G-1:0] mSnaps[$];
  int           mHead;
  bit           mErr;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t modelExp();
    exp_t e;
    e.ghrV   = int'(mGhr);
    e.countV = mSnaps.size();
    e.readyV = (mSnaps.size() < D) ? 1 : 0;
    e.tagV   = (mHead + mSnaps.size()) % D;
    e.errV   = mErr ? 1 : 0;
    return e;
  endfunction

  task automatic modelReset();
    mGhr  = '0;
    mSnaps.delete();
    mHead = 0;
    mErr  = 1'b0;
  endtask

  task automatic modelStep(input bit pv, input bit pt, input bit rv,
                           input bit fv, input int ftag, input bit ft);
    int  cnt;
    int  idx;
    bit  retOk;
    bit  flushOk;
    bit  accept;
    cnt   = mSnaps.size();
    retOk = rv && (cnt > 0);
    idx   = -1;
    if (fv) begin
      for (int i = 0; i < cnt; i++) begin
        if (((mHead + i) % D) == ftag) idx = i;
      end
    end
    flushOk = fv && (idx >= 0) && !(retOk && idx == 0);
    if ((fv && !flushOk) || (rv && cnt == 0)) mErr = 1'b1;
    accept = pv && (cnt < D) && !fv;
    if (flushOk) begin
      mGhr = {mSnaps[idx][G-2:0], ft};
      while (mSnaps.size() > idx + 1) void'(mSnaps.pop_back());
    end else if (accept) begin
      mSnaps.push_back(mGhr);
      mGhr = {mGhr[G-2:0], pt};
    end
    if (retOk) begin
      void'(mSnaps.pop_front());
      mHead = (mHead + 1) % D;
    end
  endtask

  // Drive one cycle of inputs; the model's post-edge prediction goes to the scoreboard.
  task automatic applyStimulus(input bit pv, input bit pt, input bit rv,
                               input bit fv, input int ftag, input bit ft);
    exp_t pre;
    pred_valid   = pv;
    pred_taken   = pt;
    retire_valid = rv;
    flush_valid  = fv;
    flush_tag    = TW'(ftag);
    flush_taken  = ft;
    #1;
    pre = modelExp();
    check("pre_ready", int'(pred_ready), pre.readyV);
    check("pre_tag", int'(pred_tag), pre.tagV);
    @(posedge clk);
    modelStep(pv, pt, rv, fv, ftag, ft);
    expQ.push_back(modelExp());
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Reset is asserted between edges and checked before the next edge arrives.
  task automatic doReset();
    pred_valid   = 1'b0;
    retire_valid = 1'b0;
    flush_valid  = 1'b0;
    @(negedge clk);
    #1;
    rst_l = 1'b0;
    #1;
    check("rst_ghr", int'(ghr), 0);
    check("rst_count", int'(chkpt_count), 0);
    check("rst_err", int'(chkpt_err), 0);
    check("rst_ready", int'(pred_ready), 1);
    check("rst_tag", int'(pred_tag), 0);
    modelReset();
    @(posedge clk);
    #2;
    rst_l = 1'b1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("ghr", int'(ghr), e.ghrV);
      check("chkpt_count", int'(chkpt_count), e.countV);
      check("pred_ready", int'(pred_ready), e.readyV);
      check("pred_tag", int'(pred_tag), e.tagV);
      check("chkpt_err", int'(chkpt_err), e.errV);
    end
  end

  task automatic checkOutput(input string name, input int ghrExp, input int cntExp, input int errExp);
    @(negedge clk);
    #1;
    check({name, "_ghr"}, int'(ghr), ghrExp);
    check({name, "_count"}, int'(chkpt_count), cntExp);
    check({name, "_err"}, int'(chkpt_err), errExp);
  endtask

  initial begin
    int cnt;
    bit rv;
    bit fv;
    int ftag;

    modelReset();
    doReset();

    // Three taken predictions: tags 0,1,2 and history 0x07.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("three_taken", 8'h07, 3, 0);

    // Fill, attempt a fifth prediction, then retire one.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'(i & 1), 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("full_hold", 8'h05, 4, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle();

    // T,N,T then flush tag 1 resolved taken: history 0x03, two in flight.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    checkOutput("flush_mid", 8'h03, 2, 0);
    idle();

    // Flush tag 0 together with a prediction: the prediction is dropped.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("flush_vs_pred", 8'h00, 1, 0);

    // Retire and flush of a younger branch together, then of the retiring head.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    idle();

    // Retire while empty sets the sticky error.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle();
    checkOutput("retire_empty", 8'h00, 0, 1);

    // Flush of an unallocated tag sets the error and changes nothing else.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    checkOutput("flush_illegal", 8'h03, 2, 1);

    // Mid-operation reset with three in flight, then the first tag is 0 again.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle();

    // Random legal traffic exercising wrap-around.
    doReset();
    for (int n = 0; n < 500; n++) begin
      cnt  = mSnaps.size();
      rv   = (cnt > 0) && ($urandom_range(2) == 0);
      fv   = (cnt > 0) && ($urandom_range(5) == 0);
      ftag = (cnt > 0) ? (mHead + int'($urandom_range(cnt - 1))) % D : 0;
      if (rv && fv && ftag == mHead) begin
        if (cnt > 1) ftag = (mHead + 1) % D;
        else fv = 1'b0;
      end
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), rv, fv, ftag,
                    1'($urandom_range(1)));
    end

    // Unconstrained random traffic, including protocol errors.
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)),
                    ($urandom_range(3) == 0), ($urandom_range(4) == 0),
                    int'($urandom_range(D - 1)), 1'($urandom_range(1)));
    end
    idle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
